factor_display_reader: RTL and testbench
========================================

# factor_display_reader

Receive-side counterpart to the factorizer's seven-segment output. Samples the 7-bit segment stream and debounces each displayed glyph. Decodes glyphs to digits, tracks the ascending divisor sequence 1, d2, d3, … that repeats on the display, and reconstructs the 8-bit factor mask once per sequence. Used in the bench harness and as an on-chip loopback checker fed from `uo_out[6:0]`.

## Interface
Parameters:
- `STABLE_CYCLES`, default 16: consecutive identical samples required to accept a glyph; minimum 2.
- `MAX_HOLD`, default 10_000_000: cycles digit 1 may stay accepted before an empty mask is reported.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `segments_in` in 7: segment levels, active high; bit0 = a … bit6 = g.
- `digit_out` out 4: last accepted digit.
- `digit_valid` out 1: one-cycle pulse when a new digit is accepted.
- `factors_out` out 8: bit i set means divisor i+2 was seen (bit0 = 2 … bit7 = 9).
- `factors_valid` out 1: one-cycle pulse when `factors_out` is updated.
- `error` out 1: one-cycle pulse on an invalid glyph or an out-of-order sequence.

## Operation
- **Glyph table** (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any other pattern is invalid.
- **Debounce**
  - `segments_in` is registered every cycle.
  - The stability counter clears whenever the sample differs from the previous one, and saturates at `STABLE_CYCLES`.
  - An accept event fires once, when the counter reaches `STABLE_CYCLES` and the pattern differs from the last accepted pattern.
  - Re-showing the same glyph after a sub-threshold glitch produces no event.
- **Accept event**
  - Valid glyph: load `digit_out` and pulse `digit_valid`.
  - Invalid glyph: pulse `error`, go to SYNC, leave `digit_out` unchanged.
- **FSM**
  - SYNC: wait for digit 1. Then clear the working mask, set `last` = 1, clear the hold counter, go to COLLECT. Other digits are ignored silently.
  - COLLECT, digit d in 2..9 with d > `last`: set mask bit d-2, set `last` = d.
  - COLLECT, digit d in 2..9 with d ≤ `last`: pulse `error`, go to SYNC.
  - COLLECT, digit 1 with `last` > 1: copy the working mask to `factors_out`, pulse `factors_valid`, clear the working mask, set `last` = 1, stay in COLLECT.
  - COLLECT, digit 0: go to SYNC, no error. Digit 0 is the display's reset glyph.
- **Hold timeout**
  - In COLLECT with `last` = 1 and no accept event, the hold counter increments.
  - On reaching `MAX_HOLD`, set `factors_out` = 00 and pulse `factors_valid` once. The counter saturates, so there is no repeat until the next accept event.
  - Any accept event clears the counter.
- **Widths**
  - Stability counter: $clog2(STABLE_CYCLES+1) bits.
  - Hold counter: $clog2(MAX_HOLD+1) bits, saturating; never wraps.
- **Simultaneous events:** an accept event takes priority over the timeout in the same cycle.

## Timing
- **Reset values:**
  - All outputs 0.
  - FSM in SYNC, working mask 0, `last` 0.
  - Counters 0; the last-accepted pattern register holds 00 (matches no valid glyph).
- **Reset mid-sequence:** aborts without a `factors_valid` pulse. The first report after reset needs a complete 1 … 1 sequence.
- **Acceptance latency:** a pattern first sampled at edge N gives `digit_valid` high in the cycle after edge N+STABLE_CYCLES.
- **Pulse alignment:**
  - `factors_valid` for a closing 1 coincides with its `digit_valid`.
  - `error` coincides with the offending accept event.
- **Output stability:** `factors_out` and `digit_out` hold until the next update. Pulses are exactly one cycle wide.
- **Input changes:** a change every cycle never produces an accept event.

## Structure
- **Package `factor_display_pkg`:**
  - the ten glyph constants;
  - FSM state enum {SYNC, COLLECT};
  - mask width constant 8;
  - lowest divisor constant 2.
- **Sub-module `seg7_to_digit`:** combinational decode of 7 bits to {valid, digit[3:0]}, reusable by other checkers.
- **Top level:** sampling, debounce, hold counter and FSM, roughly 150–250 lines in total.

## Test plan
Benches use `STABLE_CYCLES`=4 and `MAX_HOLD`=100. "×N" means the glyph is held for N cycles.

1. Glyphs 1,2,3,4,6,1, each ×20 → `factors_valid` pulse with `factors_out`=17, aligned with the second digit_valid(1).
2. Glyphs 0,1,7,1,7,1 ×20 → two `factors_valid` pulses, both with value 20. The leading 0 keeps the FSM in SYNC without error.
3. Glyph 3 ×20 interrupted by 7F for 2 cycles → no `digit_valid` for the glitch, no repeat event for 3. A 7F held ×10 → `digit_valid` with digit 8.
4. Glyphs 1,4,2 ×20 → `error` pulse on the accept of 2. A following 1,5,1 → `factors_valid` with 08.
5. Glyph 1 ×300 after SYNC → exactly one `factors_valid` with 00, about 100 cycles after the accept of 1. Pattern 49 held ×10 → one `error` pulse.
6. `reset` asserted mid-sequence (after 1,2) → all outputs 0 next cycle. A following 3,1 produces no `factors_valid`. A full 1,5,1 → 08.

Source files
------------

// File: rtl/factor_display_reader_pkg.sv
// Shared constants for the seven-segment readback path: glyph encodings,
// FSM state type and factor-mask geometry.
package factor_display_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;

  typedef enum logic {
    SYNC,
    COLLECT
  } state_t;

  localparam int MASK_WIDTH     = 8;
  localparam int LOWEST_DIVISOR = 2;

endpackage

// File: rtl/factor_display_reader_if.sv
// Result bundle produced by the display reader: decoded digit, factor mask
// and the single-cycle event pulses that accompany them.
interface factor_display_reader_if;
  import factor_display_pkg::*;

  logic [3:0]            digit_out;
  logic                  digit_valid;
  logic [MASK_WIDTH-1:0] factors_out;
  logic                  factors_valid;
  logic                  error;

  modport master (
    output digit_out,
    output digit_valid,
    output factors_out,
    output factors_valid,
    output error
  );

  modport slave (
    input digit_out,
    input digit_valid,
    input factors_out,
    input factors_valid,
    input error
  );

endinterface

// File: rtl/factor_display_reader_seg7_to_digit.sv
// Pure combinational seven-segment to BCD decoder; anything outside the
// ten known glyphs is flagged invalid with digit forced to zero.
module seg7_to_digit
  import factor_display_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] digit
);

  // Table lookup of the ten legal glyphs.
  always_comb begin
    valid = 1'b1;
    digit = 4'd0;
    case (seg)
      GLYPH_0: digit = 4'd0;
      GLYPH_1: digit = 4'd1;
      GLYPH_2: digit = 4'd2;
      GLYPH_3: digit = 4'd3;
      GLYPH_4: digit = 4'd4;
      GLYPH_5: digit = 4'd5;
      GLYPH_6: digit = 4'd6;
      GLYPH_7: digit = 4'd7;
      GLYPH_8: digit = 4'd8;
      GLYPH_9: digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/factor_display_reader.sv
// Reads back the factorizer's seven-segment stream: debounces glyphs, decodes
// them, follows the ascending divisor sequence 1, d2, d3, ... and rebuilds
// the factor mask each time the sequence wraps back to 1.
module factor_display_reader
  import factor_display_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int MAX_HOLD      = 10_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segments_in,
  factor_display_reader_if.master result
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STABLE_M1  = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_M1    = HW'(MAX_HOLD - 1);
  localparam logic [3:0]    LOW_DIGIT  = 4'(LOWEST_DIVISOR);

  logic [6:0]            sample_q;
  logic [6:0]            accepted_q;
  logic [SW-1:0]         stable_cnt;
  logic                  accept;

  logic                  dec_valid;
  logic [3:0]            dec_digit;
  logic [2:0]            bit_idx;

  state_t                state_q, state_d;
  logic [MASK_WIDTH-1:0] mask_q, mask_d;
  logic [3:0]            last_q, last_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [3:0]            digit_q, digit_d;
  logic [MASK_WIDTH-1:0] fout_q, fout_d;
  logic                  dvalid_q, dvalid_d;
  logic                  fvalid_q, fvalid_d;
  logic                  err_q, err_d;

  seg7_to_digit u_decode (
    .seg   (sample_q),
    .valid (dec_valid),
    .digit (dec_digit)
  );

  assign accept  = (segments_in == sample_q) && (stable_cnt == STABLE_M1) &&
                   (sample_q != accepted_q);
  assign bit_idx = 3'(dec_digit - LOW_DIGIT);

  // Sample the segments, count how long they stay put, remember the last glyph taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q   <= '0;
      stable_cnt <= '0;
      accepted_q <= '0;
    end else begin
      sample_q <= segments_in;
      if (segments_in != sample_q)
        stable_cnt <= '0;
      else if (stable_cnt != STABLE_MAX)
        stable_cnt <= stable_cnt + 1'b1;
      if (accept)
        accepted_q <= sample_q;
    end
  end

  // Register FSM state, sequence tracking and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SYNC;
      mask_q   <= '0;
      last_q   <= '0;
      hold_q   <= '0;
      digit_q  <= '0;
      fout_q   <= '0;
      dvalid_q <= 1'b0;
      fvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      digit_q  <= digit_d;
      fout_q   <= fout_d;
      dvalid_q <= dvalid_d;
      fvalid_q <= fvalid_d;
      err_q    <= err_d;
    end
  end

  // Accepted glyphs drive the sequence tracker; otherwise a lone 1 ages toward an empty report.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    last_d   = last_q;
    hold_d   = hold_q;
    digit_d  = digit_q;
    fout_d   = fout_q;
    dvalid_d = 1'b0;
    fvalid_d = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      hold_d = '0;
      if (!dec_valid) begin
        err_d   = 1'b1;
        state_d = SYNC;
      end else begin
        digit_d  = dec_digit;
        dvalid_d = 1'b1;
        case (state_q)
          SYNC: begin
            if (dec_digit == 4'd1) begin
              mask_d  = '0;
              last_d  = 4'd1;
              state_d = COLLECT;
            end
          end
          COLLECT: begin
            if (dec_digit == 4'd0) begin
              state_d = SYNC;
            end else if (dec_digit == 4'd1) begin
              if (last_q > 4'd1) begin
                fout_d   = mask_q;
                fvalid_d = 1'b1;
                mask_d   = '0;
                last_d   = 4'd1;
              end
            end else if (dec_digit > last_q) begin
              mask_d[bit_idx] = 1'b1;
              last_d          = dec_digit;
            end else begin
              err_d   = 1'b1;
              state_d = SYNC;
            end
          end
          default: state_d = SYNC;
        endcase
      end
    end else if (state_q == COLLECT && last_q == 4'd1 && hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
      if (hold_q == HOLD_M1) begin
        fout_d   = '0;
        fvalid_d = 1'b1;
      end
    end
  end

  assign result.digit_out     = digit_q;
  assign result.digit_valid   = dvalid_q;
  assign result.factors_out   = fout_q;
  assign result.factors_valid = fvalid_q;
  assign result.error         = err_q;

endmodule

// File: tb/tb_factor_display_reader.sv
// Directed bench for factor_display_reader with STABLE_CYCLES=4, MAX_HOLD=100.
module tb_factor_display_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] segments = 7'h00;

  factor_display_reader_if bus ();

  factor_display_reader #(
    .STABLE_CYCLES (4),
    .MAX_HOLD      (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .segments_in (segments),
    .result      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int cycle = 0;
  int dv_cnt = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int dv_cycle = 0;
  int fv_cycle = 0;
  logic [7:0] fv_value = 8'h00;
  logic       fv_aligned = 1'b0;

  // Count rising edges so event spacing can be measured.
  always @(posedge clk) cycle <= cycle + 1;

  // Watch the pulse outputs between edges and log what they carried.
  always @(negedge clk) begin
    if (bus.digit_valid) begin
      dv_cnt   = dv_cnt + 1;
      dv_cycle = cycle;
    end
    if (bus.factors_valid) begin
      fv_cnt     = fv_cnt + 1;
      fv_cycle   = cycle;
      fv_value   = bus.factors_out;
      fv_aligned = bus.digit_valid;
    end
    if (bus.error) err_cnt = err_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] pattern, input int cycles);
    @(negedge clk);
    segments = pattern;
    repeat (cycles - 1) @(negedge clk);
  endtask

  int dv0, fv0, err0;

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    check_output("reset_digit_out", bus.digit_out, 0);
    check_output("reset_digit_valid", bus.digit_valid, 0);
    check_output("reset_factors_out", bus.factors_out, 0);
    check_output("reset_factors_valid", bus.factors_valid, 0);
    check_output("reset_error", bus.error, 0);
    reset = 1'b0;

    // Changing every cycle never yields an event.
    dv0 = dv_cnt; err0 = err_cnt;
    for (int i = 0; i < 30; i++) apply_stimulus((i % 2) ? 7'h06 : 7'h3F, 1);
    apply_stimulus(7'h00, 8);
    check_output("toggle_no_dv", dv_cnt - dv0, 0);
    check_output("toggle_no_err", err_cnt - err0, 0);

    // Acceptance latency and pulse width on glyph 1.
    @(negedge clk);
    segments = 7'h06;
    repeat (4) @(negedge clk);
    check_output("latency_early", bus.digit_valid, 0);
    @(negedge clk);
    check_output("latency_hit", bus.digit_valid, 1);
    check_output("latency_digit", bus.digit_out, 1);
    @(negedge clk);
    check_output("latency_width", bus.digit_valid, 0);
    repeat (14) @(negedge clk);

    // Test 1: 1,2,3,4,6,1 -> 0x17.
    fv0 = fv_cnt;
    apply_stimulus(7'h5B, 20);
    apply_stimulus(7'h4F, 20);
    apply_stimulus(7'h66, 20);
    apply_stimulus(7'h7D, 20);
    apply_stimulus(7'h06, 20);
    check_output("t1_fv_count", fv_cnt - fv0, 1);
    check_output("t1_value", fv_value, 8'h17);
    check_output("t1_aligned", fv_aligned, 1);
    check_output("t1_hold_value", bus.factors_out, 8'h17);

    // Test 2: 0,1,7,1,7,1 -> two reports of 0x20.
    fv0 = fv_cnt; err0 = err_cnt;
    apply_stimulus(7'h3F, 20);
    apply_stimulus(7'h06, 20);
    apply_stimulus(7'h07, 20);
    apply_stimulus(7'h06, 20);
    check_output("t2_first_value", fv_value, 8'h20);
    apply_stimulus(7'h07, 20);
    apply_stimulus(7'h06, 20);
    check_output("t2_fv_count", fv_cnt - fv0, 2);
    check_output("t2_value", fv_value, 8'h20);
    check_output("t2_no_err", err_cnt - err0, 0);

    // Test 3: glitch suppression, then a held 7F decodes as 8.
    dv0 = dv_cnt; err0 = err_cnt;
    apply_stimulus(7'h4F, 20);
    apply_stimulus(7'h7F, 2);
    apply_stimulus(7'h4F, 20);
    check_output("t3_glitch_dv", dv_cnt - dv0, 1);
    check_output("t3_digit3", bus.digit_out, 3);
    apply_stimulus(7'h7F, 10);
    check_output("t3_dv_total", dv_cnt - dv0, 2);
    check_output("t3_digit8", bus.digit_out, 8);
    check_output("t3_no_err", err_cnt - err0, 0);

    // Test 4: 1,4,2 errors on the 2; then 1,5,1 -> 0x08.
    err0 = err_cnt;
    apply_stimulus(7'h06, 20);
    check_output("t4_close_38", fv_value, 8'h42);
    apply_stimulus(7'h66, 20);
    check_output("t4_err_before", err_cnt - err0, 0);
    apply_stimulus(7'h5B, 20);
    check_output("t4_err_on_2", err_cnt - err0, 1);
    fv0 = fv_cnt;
    apply_stimulus(7'h06, 20);
    apply_stimulus(7'h6D, 20);
    apply_stimulus(7'h06, 20);
    check_output("t4_fv_count", fv_cnt - fv0, 1);
    check_output("t4_value", fv_value, 8'h08);

    // Test 5: a lone 1 times out once with an empty mask; 49 is invalid.
    apply_stimulus(7'h3F, 20);
    fv0 = fv_cnt;
    apply_stimulus(7'h06, 300);
    check_output("t5_fv_count", fv_cnt - fv0, 1);
    check_output("t5_value", fv_value, 8'h00);
    check_output("t5_delay", fv_cycle - dv_cycle, 100);
    check_output("t5_not_aligned", fv_aligned, 0);
    err0 = err_cnt; dv0 = dv_cnt;
    apply_stimulus(7'h49, 10);
    check_output("t5_err_count", err_cnt - err0, 1);
    check_output("t5_no_dv", dv_cnt - dv0, 0);
    check_output("t5_digit_kept", bus.digit_out, 1);

    // Test 6: reset mid-sequence clears outputs and aborts the sequence.
    apply_stimulus(7'h06, 20);
    apply_stimulus(7'h5B, 20);
    check_output("t6_pre_digit", bus.digit_out, 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("t6_rst_digit", bus.digit_out, 0);
    check_output("t6_rst_factors", bus.factors_out, 0);
    check_output("t6_rst_pulses", {bus.digit_valid, bus.factors_valid, bus.error}, 0);
    reset = 1'b0;
    fv0 = fv_cnt;
    apply_stimulus(7'h4F, 20);
    apply_stimulus(7'h06, 20);
    check_output("t6_no_fv", fv_cnt - fv0, 0);
    apply_stimulus(7'h6D, 20);
    apply_stimulus(7'h06, 20);
    check_output("t6_fv_count", fv_cnt - fv0, 1);
    check_output("t6_value", fv_value, 8'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
